// File: rtl/poly_tone_pkg.sv
// poly_tone_pkg: shared types and helpers for the polyphonic tone generator
package poly_tone_pkg;

    typedef enum logic [1:0] {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE} env_state_t;
    typedef enum logic [1:0] {WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_MUTE} wave_mode_t;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
    endfunction

    // p is an unsigned w-bit phase; the result is a signed w-bit sample
    function automatic logic signed [31:0] wave_shape(input wave_mode_t m, input logic [31:0] p, input int w);
        logic [31:0] half, f;
        half = 32'd1 << (w - 1);
        f = p >= half ? (half << 1) - 32'd1 - p : p;
        return m == WAVE_SQUARE ? (p >= half ? -$signed(half - 32'd1) : $signed(half - 32'd1)) :
               m == WAVE_SAW    ? $signed(p - half) :
               m == WAVE_TRI    ? $signed((f << 1) - half) : 32'sd0;
    endfunction

endpackage

// File: rtl/tone_voice_datapath.sv
// tone_voice_datapath: envelope step, waveform and scaling for the voice currently selected by the sequencer
module tone_voice_datapath
    import poly_tone_pkg::*;
#(
    parameter int PHASE_W      = 24,
    parameter int OUT_W        = 16,
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  env_state_t                 state,
    input  logic [ENV_W-1:0]           env,
    input  logic [PHASE_W-1:0]         phase,
    input  logic [PHASE_W-1:0]         inc,
    input  logic                       btn,
    input  wave_mode_t                 mode,
    input  logic                       low_batt,
    output env_state_t                 state_nxt,
    output logic [ENV_W-1:0]           env_nxt,
    output logic [PHASE_W-1:0]         phase_nxt,
    output logic signed [OUT_W-1:0]    sample
);
    localparam int PROD_W = OUT_W + ENV_W + 1;
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    env_state_t gated;
    logic [ENV_W:0] env_sum;
    logic [ENV_W-1:0] env_up, env_dn;
    logic [PHASE_W-1:0] phase_base, eff_inc;
    logic [OUT_W-1:0] p;
    logic signed [OUT_W-1:0] wave;
    logic signed [PROD_W-1:0] prod;

    // a press from IDLE restarts the waveform at phase zero
    assign phase_base = state == ENV_IDLE ? '0 : phase;

    if (PHASE_W >= OUT_W) begin : g_top
        assign p = phase_base[PHASE_W-1 -: OUT_W];
    end else begin : g_pad
        assign p = {phase_base, {(OUT_W - PHASE_W){1'b0}}};
    end

    always_comb begin
        gated = btn && (state == ENV_IDLE || state == ENV_RELEASE) ? ENV_ATTACK :
                !btn && (state == ENV_ATTACK || state == ENV_SUSTAIN) ? ENV_RELEASE : state;
        env_sum = {1'b0, env} + (ENV_W + 1)'(ATTACK_STEP);
        env_up = env_sum > {1'b0, ENV_MAX} ? ENV_MAX : env_sum[ENV_W-1:0];
        env_dn = env > ENV_W'(RELEASE_STEP) ? env - ENV_W'(RELEASE_STEP) : '0;
        env_nxt = gated == ENV_ATTACK ? env_up : gated == ENV_RELEASE ? env_dn : env;
        state_nxt = gated == ENV_ATTACK && env_up == ENV_MAX ? ENV_SUSTAIN :
                    gated == ENV_RELEASE && env_dn == '0 ? ENV_IDLE : gated;
        eff_inc = low_batt ? inc - (inc >> 4) : inc;
        phase_nxt = state_nxt == ENV_IDLE ? phase_base : phase_base + eff_inc;
        wave = OUT_W'(wave_shape(mode, 32'(p), OUT_W));
        prod = PROD_W'(wave) * PROD_W'($signed({1'b0, env_nxt}));
        sample = state_nxt == ENV_IDLE ? '0 : OUT_W'(prod >>> ENV_W);
    end

endmodule

// File: rtl/poly_tone_voices.sv
// poly_tone_voices: time-multiplexed polyphonic tone generator with per-voice ASR envelopes
// and a saturating mixer producing one signed PCM word per sample tick.
module poly_tone_voices
    import poly_tone_pkg::*;
#(
    parameter int NUM_VOICES   = 8,
    parameter int CLK_HZ       = 50000000,
    parameter int SAMPLE_HZ    = 48000,
    parameter int PHASE_W      = 24,
    parameter int OUT_W        = 16,
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2,
    parameter int MIX_SHIFT    = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_VOICES-1:0]           btn,
    input  logic [NUM_VOICES*PHASE_W-1:0]   phase_inc,
    input  logic [1:0]                      wave_mode,
    input  logic                            low_batt,
    output logic signed [OUT_W-1:0]         pcm_out,
    output logic                            sample_strobe,
    output logic [NUM_VOICES-1:0]           voice_active
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int ACC_W = OUT_W + $clog2(NUM_VOICES) + 1;
    localparam int SEQ_W = $clog2(NUM_VOICES + 2);
    localparam int VS_W  = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;

    if (DIV < NUM_VOICES + 3 || NUM_VOICES < 1 || NUM_VOICES > 16) begin : g_bad_cfg
        $error("poly_tone_voices: need NUM_VOICES in 1..16 and CLK_HZ/SAMPLE_HZ >= NUM_VOICES+3");
    end

    logic [DIV_W-1:0] div_cnt;
    logic tick, seq_run;
    logic [SEQ_W-1:0] seq;
    logic [VS_W-1:0] vsel;
    logic [NUM_VOICES-1:0] btn_l;
    logic [NUM_VOICES*PHASE_W-1:0] inc_l;
    wave_mode_t mode_l;
    logic low_batt_l;
    env_state_t state_q [NUM_VOICES];
    logic [ENV_W-1:0] env_q [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic signed [ACC_W-1:0] acc, acc_shr;
    env_state_t state_nxt;
    logic [ENV_W-1:0] env_nxt;
    logic [PHASE_W-1:0] phase_nxt;
    logic signed [OUT_W-1:0] voice_sample;

    assign tick = div_cnt == DIV_W'(DIV - 1);
    assign vsel = seq < SEQ_W'(NUM_VOICES) ? VS_W'(seq) : '0;
    assign acc_shr = acc >>> MIX_SHIFT;

    tone_voice_datapath #(
        .PHASE_W      (PHASE_W),
        .OUT_W        (OUT_W),
        .ENV_W        (ENV_W),
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_datapath (
        .state     (state_q[vsel]),
        .env       (env_q[vsel]),
        .phase     (phase_q[vsel]),
        .inc       (inc_l[vsel * PHASE_W +: PHASE_W]),
        .btn       (btn_l[vsel]),
        .mode      (mode_l),
        .low_batt  (low_batt_l),
        .state_nxt (state_nxt),
        .env_nxt   (env_nxt),
        .phase_nxt (phase_nxt),
        .sample    (voice_sample)
    );

    // seq 0..NUM_VOICES-1 visits voices, NUM_VOICES is a settle slot, NUM_VOICES+1 publishes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt       <= '0;
            seq_run       <= 1'b0;
            seq           <= '0;
            acc           <= '0;
            pcm_out       <= '0;
            sample_strobe <= 1'b0;
            btn_l         <= '0;
            inc_l         <= '0;
            mode_l        <= WAVE_SQUARE;
            low_batt_l    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= ENV_IDLE;
                env_q[i]   <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            div_cnt       <= tick ? '0 : div_cnt + DIV_W'(1);
            sample_strobe <= 1'b0;
            if (tick) begin
                btn_l      <= btn;
                inc_l      <= phase_inc;
                mode_l     <= wave_mode_t'(wave_mode);
                low_batt_l <= low_batt;
                acc        <= '0;
                seq        <= '0;
                seq_run    <= 1'b1;
            end else if (seq_run) begin
                seq <= seq + SEQ_W'(1);
                if (seq < SEQ_W'(NUM_VOICES)) begin
                    state_q[vsel] <= state_nxt;
                    env_q[vsel]   <= env_nxt;
                    phase_q[vsel] <= phase_nxt;
                    acc           <= acc + ACC_W'(voice_sample);
                end
                if (seq == SEQ_W'(NUM_VOICES + 1)) begin
                    pcm_out       <= OUT_W'(sat_signed(64'(acc_shr), OUT_W));
                    sample_strobe <= 1'b1;
                    seq_run       <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) voice_active[i] = state_q[i] != ENV_IDLE;
    end

endmodule
